register_bank_mp: RTL

- Parametrised multi-port successor to the single-issue register bank.
- Provides NRD independent read ports, two write sources (ALU writeback, memory load return), optional write-to-read bypass, optional hardwired zero register.
- Adds a per-register load scoreboard so decode can detect registers awaiting an outstanding load.
- Sits between decode (reads, load issue) and writeback/memory stages (writes).

---
 rtl/register_bank_mp.sv | 108 ++++++++++
 1 files changed

// File: rtl/register_bank_mp.sv
// Multi-port register bank with two write sources (ALU writeback and load
// return), optional write-to-read bypass, optional hardwired zero register,
// and a per-register scoreboard that tracks outstanding loads.
module register_bank_mp #(
  parameter  int XLEN     = 32,
  parameter  int NREGS    = 32,
  parameter  int NRD      = 2,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                 stage_clk,
  input  logic                 reset_n,
  input  logic [NRD*AW-1:0]    rs_addr,
  output logic [NRD*XLEN-1:0]  rs_data,
  output logic [NRD-1:0]       rs_busy,
  input  logic                 alu_we,
  input  logic [AW-1:0]        alu_rd,
  input  logic [XLEN-1:0]      alu_data,
  input  logic                 mem_we,
  input  logic [AW-1:0]        mem_rd,
  input  logic [XLEN-1:0]      mem_data,
  input  logic                 ld_issue,
  input  logic [AW-1:0]        ld_rd,
  output logic                 ld_reject,
  output logic [AW:0]          pend_cnt
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NREGS-1:0] pend_q, pend_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             ld_set;

  // True when the address names the hardwired zero register.
  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Register file next state: the memory write is applied last so it wins
  // over an ALU write to the same register.
  always_comb begin
    // NOTE: start from the held value so every path assigns regs_d and no latch is inferred.
    regs_d = regs_q;
    if (alu_we && !is_zero(alu_rd)) regs_d[alu_rd] = alu_data;
    if (mem_we && !is_zero(mem_rd)) regs_d[mem_rd] = mem_data;
  end

  // A load to a pending register is refused unless that register's return
  // lands in this very cycle.
  assign ld_reject = ld_issue && pend_q[ld_rd] && !(mem_we && (mem_rd == ld_rd));
  assign ld_set    = ld_issue && !ld_reject && !is_zero(ld_rd);

  // Scoreboard next state: clear on load return, then set on accepted issue
  // (set wins on the same register); the count is the population of the result.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so later statements see earlier results.
    pend_d = pend_q;
    if (mem_we) pend_d[mem_rd] = 1'b0;
    if (ld_set) pend_d[ld_rd]  = 1'b1;
    cnt_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt_d = cnt_d + (AW+1)'(pend_d[i]);
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge stage_clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the storage array is reset on purpose so every register reads 0 after reset.
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_cnt = cnt_q;

  // Independent combinational read ports.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic            mem_hit;
    logic            alu_hit;
    logic [XLEN-1:0] data;

    assign addr    = rs_addr[k*AW +: AW];
    assign mem_hit = (BYPASS != 0) && mem_we && (mem_rd == addr);
    assign alu_hit = (BYPASS != 0) && alu_we && (alu_rd == addr);

    // Read mux: zero register, then load-return bypass, then ALU bypass, then storage.
    always_comb begin
      if (is_zero(addr))  data = '0;
      else if (mem_hit)   data = mem_data;
      else if (alu_hit)   data = alu_data;
      else                data = regs_q[addr];
    end

    assign rs_data[k*XLEN +: XLEN] = data;
    assign rs_busy[k]              = pend_q[addr] && !mem_hit;
  end

endmodule
